// File: rtl/pc_stall_ctrl_if.sv
// rtl/pc_stall_ctrl_if.sv - hazard/stall signal bundle between pipeline front end and pc_stall_ctrl
//
// Purpose: groups the D/E/M hazard inputs and the stall/enable outputs of the stall sequencer.
// Ports (modport view):
//   master - pipeline side: drives D-stage fields, E/M destination and Tnew, mult/div start;
//            receives pc_en, fd_en, de_flush, stall, md_busy, stall_cycles
//   slave  - pc_stall_ctrl side: the reverse directions

interface pc_stall_ctrl_if;
   logic [4:0]  d_rs;
   logic [4:0]  d_rt;
   logic [1:0]  d_rs_tuse;
   logic [1:0]  d_rt_tuse;
   logic        d_is_md;
   logic [4:0]  e_wa;
   logic [1:0]  e_tnew;
   logic [4:0]  m_wa;
   logic [1:0]  m_tnew;
   logic        e_md_start;
   logic        e_md_op;
   logic        pc_en;
   logic        fd_en;
   logic        de_flush;
   logic        stall;
   logic        md_busy;
   logic [31:0] stall_cycles;

   modport master (
      output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
      output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
      input  pc_en, fd_en, de_flush, stall, md_busy, stall_cycles
   );

   modport slave (
      input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
      input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
      output pc_en, fd_en, de_flush, stall, md_busy, stall_cycles
   );
endinterface

// File: rtl/pc_stall_ctrl.sv
// rtl/pc_stall_ctrl.sv - Tuse/Tnew hazard and mult/div busy stall sequencer
//
// Purpose: produces PC enable, F/D enable and D/E flush from register dependences and a
//          cycle-counting mult/div busy tracker; counts stalled cycles (saturating).
// Ports:
//   clk    - pipeline clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - pc_stall_ctrl_if.slave: hazard inputs in, pc_en/fd_en/de_flush/stall/
//            md_busy/stall_cycles out
// Parameters:
//   MULT_CYCLES - busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES  - busy cycles after a div/divu start (1..15)

module pc_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   pc_stall_ctrl_if.slave  bus
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t   state;
   logic [3:0]  cnt;
   logic        md_busy_q;
   logic [31:0] stall_cnt;

   logic rs_stall;
   logic rt_stall;
   logic md_stall;
   logic stall_w;

   // A producer whose result is not ready before the consumer needs it forces a stall.
   // $0 is exempt because e_wa/m_wa == 0 means "no destination".
   assign rs_stall = (bus.d_rs != 5'd0) &&
                     (((bus.d_rs == bus.e_wa) && (bus.d_rs_tuse < bus.e_tnew)) ||
                      ((bus.d_rs == bus.m_wa) && (bus.d_rs_tuse < bus.m_tnew)));

   assign rt_stall = (bus.d_rt != 5'd0) &&
                     (((bus.d_rt == bus.e_wa) && (bus.d_rt_tuse < bus.e_tnew)) ||
                      ((bus.d_rt == bus.m_wa) && (bus.d_rt_tuse < bus.m_tnew)));

   // Including the start pulse holds an mfhi/mflo that sits directly behind the mult/div.
   assign md_stall = bus.d_is_md && (md_busy_q || bus.e_md_start);

   assign stall_w = rs_stall || rt_stall || md_stall;

   assign bus.stall        = stall_w;
   assign bus.pc_en        = ~stall_w;
   assign bus.fd_en        = ~stall_w;
   assign bus.de_flush     = stall_w;
   assign bus.md_busy      = md_busy_q;
   assign bus.stall_cycles = stall_cnt;

   // Mult/div busy tracker. A start seen while BUSY is ignored; the D-stage md_stall
   // normally keeps a second mult/div from reaching E during that window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         md_busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.e_md_start) begin
                  state     <= BUSY;
                  cnt       <= bus.e_md_op ? DIV_CNT : MULT_CNT;
                  md_busy_q <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt > 4'd1) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state     <= IDLE;
                  cnt       <= 4'd0;
                  md_busy_q <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= 4'd0;
               md_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Saturating stall-cycle counter; a combined data + md stall counts once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 32'd0;
      end else if (stall_w && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// tb/tb_pc_stall_ctrl.sv - self-checking bench for pc_stall_ctrl

module tb_pc_stall_ctrl;

   logic clk;
   logic reset;

   pc_stall_ctrl_if bus ();

   pc_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] d_rs;
      logic [4:0] d_rt;
      logic [1:0] rs_tuse;
      logic [1:0] rt_tuse;
      logic       is_md;
      logic [4:0] e_wa;
      logic [1:0] e_tnew;
      logic [4:0] m_wa;
      logic [1:0] m_tnew;
      logic       exp_stall;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.d_rs = 5'd0; bus.d_rt = 5'd0; bus.d_rs_tuse = 2'd3; bus.d_rt_tuse = 2'd3;
      bus.d_is_md = 1'b0; bus.e_wa = 5'd0; bus.e_tnew = 2'd0; bus.m_wa = 5'd0;
      bus.m_tnew = 2'd0; bus.e_md_start = 1'b0; bus.e_md_op = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_sc;
      int n;
      logic s;

      //            rs  rt  rsT rtT md ewa et mwa mt  stall
      vecs[0]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0};
      vecs[1]  = '{5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1};
      vecs[2]  = '{5'd5, 5'd0, 2'd2, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0};
      vecs[3]  = '{5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0};
      vecs[4]  = '{5'd0, 5'd7, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b1};
      vecs[5]  = '{5'd0, 5'd7, 2'd3, 2'd1, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0};
      vecs[6]  = '{5'd3, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd3, 2'd2, 1'b0};
      vecs[7]  = '{5'd9, 5'd0, 2'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0};
      vecs[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0};
      vecs[9]  = '{5'd31, 5'd0, 2'd2, 2'd3, 1'b0, 5'd31, 2'd3, 5'd0, 2'd0, 1'b1};
      vecs[10] = '{5'd0, 5'd4, 2'd3, 2'd0, 1'b0, 5'd4, 2'd1, 5'd0, 2'd0, 1'b1};

      idle_inputs();
      reset = 1'b1;
      #2;
      check("reset_md_busy", 32'(bus.md_busy), 32'd0);
      check("reset_stall_cycles", bus.stall_cycles, 32'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      check("idle_outputs", {28'd0, bus.stall, bus.pc_en, bus.fd_en, bus.de_flush}, 32'b0110);
      step();
      check("idle_stall_cycles", bus.stall_cycles, 32'd0);

      // Register-hazard table, mult/div idle
      exp_sc = 0;
      foreach (vecs[i]) begin
         bus.d_rs = vecs[i].d_rs; bus.d_rt = vecs[i].d_rt;
         bus.d_rs_tuse = vecs[i].rs_tuse; bus.d_rt_tuse = vecs[i].rt_tuse;
         bus.d_is_md = vecs[i].is_md; bus.e_wa = vecs[i].e_wa; bus.e_tnew = vecs[i].e_tnew;
         bus.m_wa = vecs[i].m_wa; bus.m_tnew = vecs[i].m_tnew;
         #2;
         s = vecs[i].exp_stall;
         check($sformatf("vec%0d_outputs", i),
               {28'd0, bus.stall, bus.pc_en, bus.fd_en, bus.de_flush}, {28'd0, s, ~s, ~s, s});
         step();
         if (s) exp_sc++;
         check($sformatf("vec%0d_stall_cycles", i), bus.stall_cycles, 32'(exp_sc));
      end

      // Mult with mfhi in D: start cycle plus 5 busy cycles stalled
      idle_inputs();
      do_reset();
      bus.d_is_md = 1'b1; bus.e_md_start = 1'b1; bus.e_md_op = 1'b0;
      #1;
      check("mult_start_cycle_stall", 32'(bus.stall), 32'd1);
      step();
      bus.e_md_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("mult_busy_c%0d", i), {30'd0, bus.md_busy, bus.stall}, 32'b11);
         step();
      end
      check("mult_done", {30'd0, bus.md_busy, bus.stall}, 32'b00);
      check("mult_stall_cycles", bus.stall_cycles, 32'd6);

      // Div aborted by reset at busy cycle 4, then a fresh mult
      idle_inputs();
      bus.e_md_start = 1'b1; bus.e_md_op = 1'b1;
      step();
      bus.e_md_start = 1'b0;
      step(); step(); step();
      check("div_busy_c4", 32'(bus.md_busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("div_abort_md_busy", 32'(bus.md_busy), 32'd0);
      check("div_abort_stall_cycles", bus.stall_cycles, 32'd0);
      step();
      reset = 1'b0;
      step();
      check("no_residual_busy", 32'(bus.md_busy), 32'd0);
      bus.e_md_start = 1'b1; bus.e_md_op = 1'b0;
      step();
      bus.e_md_start = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.md_busy) n++;
         step();
      end
      check("mult_after_reset_busy_len", 32'(n), 32'd5);

      // Second start during div busy cycle 3 is ignored
      bus.e_md_start = 1'b1; bus.e_md_op = 1'b1;
      step();
      bus.e_md_start = 1'b0;
      n = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 3) bus.e_md_start = 1'b1;
         if (bus.md_busy) n++;
         if (i == 10) check("div_busy_c10", 32'(bus.md_busy), 32'd1);
         if (i == 11) check("div_idle_c11", 32'(bus.md_busy), 32'd0);
         step();
         bus.e_md_start = 1'b0;
      end
      check("div_restart_ignored_len", 32'(n), 32'd10);

      // Data stall and md stall together count once; start during data stall still starts FSM
      idle_inputs();
      do_reset();
      bus.d_rs = 5'd5; bus.e_wa = 5'd5; bus.e_tnew = 2'd2; bus.d_rs_tuse = 2'd1;
      bus.d_is_md = 1'b1; bus.e_md_start = 1'b1; bus.e_md_op = 1'b0;
      step();
      bus.e_md_start = 1'b0;
      check("combined_stall_once", bus.stall_cycles, 32'd1);
      check("start_during_data_stall", 32'(bus.md_busy), 32'd1);

      idle_inputs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
